// File: rtl/dco_ctrl_pkg.sv
// Shared definitions for the DCO capacitor-bank tuning controller:
// coder geometry, default ramp timing, and the ramp FSM state type.
package dco_ctrl_pkg;

  // Coder geometry: tuning word width and the row-select field inside it.
  localparam int CODER_WORD_W = 8;
  localparam int CODER_ROW_W  = 4;

  // Default ramp settings. 128 = 8 rows on, row 8 selected, column 0,
  // which matches the coder's own reset state.
  localparam int DEF_RESET_WORD = 128;
  localparam int DEF_SETTLE_CYC = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STEP   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } ramp_state_t;

endpackage

// File: rtl/dco_step_calc.sv
// Combinational step generator: moves word_out toward target by at most
// max(step_max,1). The last step is trimmed, so the word never overshoots
// and never wraps.
module dco_step_calc
  import dco_ctrl_pkg::*;
#(
  parameter int WORD_W = CODER_WORD_W,
  parameter int STEP_W = 4
) (
  input  logic [WORD_W-1:0] target,
  input  logic [WORD_W-1:0] word_out,
  input  logic [STEP_W-1:0] step_max,
  output logic [WORD_W-1:0] next_word,
  output logic              at_target
);

  logic signed [WORD_W:0] diff;
  logic [WORD_W-1:0]      mag;
  logic [WORD_W-1:0]      step_eff;
  logic [WORD_W-1:0]      step;

  // Signed distance to the target, limited step size, and the next word.
  always_comb begin
    diff      = $signed({1'b0, target}) - $signed({1'b0, word_out});
    mag       = diff[WORD_W] ? WORD_W'(-diff) : WORD_W'(diff);
    step_eff  = (step_max == '0) ? WORD_W'(1) : WORD_W'(step_max);
    step      = (mag < step_eff) ? mag : step_eff;
    next_word = diff[WORD_W] ? (word_out - step) : (word_out + step);
    at_target = (diff == '0);
  end

endmodule

// File: rtl/dco_tune_ramp.sv
// Slew-limited sequencer for the DCO capacitor-bank tuning word.
// A target word is accepted over valid/ready. The live word then walks toward
// it in bounded steps, with one coder enable pulse per step and a settle wait
// after each step.
// Optional target clamping is enabled by defining DCO_RAMP_CLAMP_EN.
module dco_tune_ramp
  import dco_ctrl_pkg::*;
#(
  parameter int WORD_W     = CODER_WORD_W,
  parameter int STEP_W     = 4,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int SETTLE_W   = 3,
  parameter int RESET_WORD = DEF_RESET_WORD,
  parameter int WORD_MIN   = 0,
  parameter int WORD_MAX   = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] tgt_word,
  input  logic              tgt_valid,
  output logic              tgt_ready,
  input  logic [STEP_W-1:0] step_max,
  input  logic              abort,
  output logic [WORD_W-1:0] word_out,
  output logic              cod_en,
  output logic              busy,
  output logic              done,
  output logic              clamp_hit
);

  ramp_state_t         state, state_nx;
  logic [WORD_W-1:0]   target;
  logic [WORD_W-1:0]   acc_word;
  logic [WORD_W-1:0]   next_word;
  logic                at_target;
  logic [SETTLE_W-1:0] settle_cnt;
  logic                fresh;       // first STEP cycle after accept: compare only
  logic                do_accept;
  logic                do_step;

  assign tgt_ready = (state == ST_IDLE) & ~abort;

  dco_step_calc #(
    .WORD_W (WORD_W),
    .STEP_W (STEP_W)
  ) u_step_calc (
    .target    (target),
    .word_out  (word_out),
    .step_max  (step_max),
    .next_word (next_word),
    .at_target (at_target)
  );

`ifdef DCO_RAMP_CLAMP_EN
  logic acc_clamped;

  // Limit the requested word to the allowed tuning range.
  always_comb begin
    acc_word    = tgt_word;
    acc_clamped = 1'b0;
    if (tgt_word < WORD_W'(WORD_MIN)) begin
      acc_word    = WORD_W'(WORD_MIN);
      acc_clamped = 1'b1;
    end else if (tgt_word > WORD_W'(WORD_MAX)) begin
      acc_word    = WORD_W'(WORD_MAX);
      acc_clamped = 1'b1;
    end
  end

  // Remember whether the most recently accepted target was clamped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            clamp_hit <= 1'b0;
    else if (do_accept) clamp_hit <= acc_clamped;
  end
`else
  logic clamp_unused;
  assign clamp_unused = (WORD_MIN > WORD_MAX);
  assign acc_word     = tgt_word;
  assign clamp_hit    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state decode and per-cycle action strobes; abort overrides all.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_nx  = state;
    do_accept = 1'b0;
    do_step   = 1'b0;
    if (abort) begin
      state_nx = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (tgt_valid) begin
            do_accept = 1'b1;
            state_nx  = ST_STEP;
          end
        end
        ST_STEP: begin
          if (fresh) begin
            state_nx = at_target ? ST_DONE : ST_STEP;
          end else begin
            do_step  = 1'b1;
            state_nx = ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == '0) state_nx = at_target ? ST_DONE : ST_STEP;
        end
        ST_DONE: state_nx = ST_IDLE;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target     <= WORD_W'(RESET_WORD);
      word_out   <= WORD_W'(RESET_WORD);
      settle_cnt <= '0;
      fresh      <= 1'b0;
      cod_en     <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      fresh  <= do_accept;
      cod_en <= do_step;
      done   <= (state == ST_DONE) & ~abort;
      busy   <= (state_nx != ST_IDLE);
      if (do_accept) target <= acc_word;
      if (do_step) begin
        word_out   <= next_word;
        settle_cnt <= SETTLE_W'(SETTLE_CYC - 1);
      end else if (state == ST_SETTLE && settle_cnt != '0) begin
        settle_cnt <= settle_cnt - SETTLE_W'(1);
      end
    end
  end

endmodule
